// File: rtl/uart_pkg.sv
// Shared UART constants: baud divider, frame shape, receiver state encoding.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
//
// Used by both the transmit and receive paths so the bit timing stays identical.
package uart_pkg;

  // Bit period minus one, in clk_i cycles (50 MHz / 9600 - 1).
  localparam logic [12:0] BAUD_DIV_DEF = 13'd5207;

  // Counter value at which the start bit is re-checked (mid-bit).
  function automatic logic [12:0] half_div(input logic [12:0] baud_div);
    return baud_div >> 1;
  endfunction

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Latency: 2 clk_i cycles from line to sync.
// Backpressure: none; free-running.
//
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset, both flops load RESET_VAL
//   line   - asynchronous input
//   sync   - synchronized copy of line
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line,
  output logic sync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= line;
      sync_q <= meta_q;
    end
  end

  assign sync = sync_q;

endmodule

// File: rtl/uart_rx_path.sv
// UART 8N1 receiver, LSB first, mid-bit sampling; one-cycle done/ferr strobes.
// Latency: done 2 + (HALF_DIV+1) + 9*(BAUD_DIV+1) clocks after the start-bit edge.
// Backpressure: none; the consumer must take uart_rx_data_o on the done strobe.
//
// Ports:
//   clk_i          - system clock
//   rst_i          - synchronous active-high reset
//   uart_rx_i      - asynchronous serial line, idle high
//   uart_rx_data_o - last good byte, held until the next good frame
//   uart_rx_done_o - one-cycle strobe, data valid on and after it
//   uart_rx_ferr_o - one-cycle strobe on a bad (low) stop bit
//   uart_rx_busy_o - high whenever the receiver is not idle
module uart_rx_path
  import uart_pkg::*;
#(
  parameter logic [12:0] BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_rx_data_o,
  output logic       uart_rx_done_o,
  output logic       uart_rx_ferr_o,
  output logic       uart_rx_busy_o
);

  localparam logic [12:0] HALF_DIV = half_div(BAUD_DIV);
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

  logic        rx_s;
  rx_state_t   state_q, state_d;
  logic [12:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .line  (uart_rx_i),
    .sync  (rx_s)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Re-check the start bit half a bit in; a short low pulse is a glitch.
        if (baud_q == HALF_DIV) begin
          baud_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 13'd1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_DIV) begin
          baud_d = '0;
          sh_d   = {rx_s, sh_q[7:1]};
          bit_d  = bit_q + 4'd1;
          if (bit_q == LAST_BIT) state_d = STOP;
        end else begin
          baud_d = baud_q + 13'd1;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit gives a back-to-back frame half a bit of
        // slack to catch its own falling edge.
        if (baud_q == BAUD_DIV) begin
          baud_d = '0;
          if (rx_s == STOP_LEVEL) begin
            data_d  = sh_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end else begin
          baud_d = baud_q + 13'd1;
        end
      end
      BRK: begin
        // Hold here until the line recovers so a break reports only once.
        baud_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign uart_rx_data_o = data_q;
  assign uart_rx_done_o = done_q;
  assign uart_rx_ferr_o = ferr_q;
  assign uart_rx_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_path.sv
// Scoreboard bench for uart_rx_path with a small serial transmitter model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_path;

  localparam int          BD_I = 15;
  localparam logic [12:0] BD   = 13'd15;
  localparam int          LAT  = 2 + (BD_I / 2 + 1) + 9 * (BD_I + 1);

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       uart_rx_i = 1'b1;
  logic [7:0] uart_rx_data_o;
  logic       uart_rx_done_o;
  logic       uart_rx_ferr_o;
  logic       uart_rx_busy_o;

  uart_rx_path #(.BAUD_DIV(BD)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .uart_rx_i      (uart_rx_i),
    .uart_rx_data_o (uart_rx_data_o),
    .uart_rx_done_o (uart_rx_done_o),
    .uart_rx_ferr_o (uart_rx_ferr_o),
    .uart_rx_busy_o (uart_rx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         launch;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         mon_lat;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_last = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk_i) begin
    if (!rst_i && (uart_rx_done_o || uart_rx_ferr_o)) begin
      if (uart_rx_done_o && uart_rx_ferr_o) begin
        check("done_and_ferr_together", 32'd1, 32'd0);
      end else if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, uart_rx_done_o, uart_rx_ferr_o}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_kind_ferr", {31'd0, uart_rx_ferr_o}, {31'd0, mon_e.is_err});
        check("data_o", {24'd0, uart_rx_data_o}, {24'd0, mon_e.data});
        check("busy_at_strobe", {31'd0, uart_rx_busy_o}, {31'd0, mon_e.is_err});
        mon_lat = cyc - mon_e.launch;
        n_tests++;
        if (mon_lat < LAT - 1 || mon_lat > LAT + 1) begin
          n_fail++;
          $display("FAIL latency: got %0d clks expected %0d +-1", mon_lat, LAT);
        end
      end
    end
  end

  // Transmitter model. Bit k occupies frame cycles [round(k*P), round((k+1)*P))
  // with P = p100/100, so fractional baud mismatch is reproduced exactly.
  // abort_at >= 0 asserts reset at that frame cycle and abandons the frame.
  // Called and returns at posedge+#1.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int p100, input int abort_at);
    logic [9:0] fr;
    int         t;
    int         dur;
    bit         aborted;
    exp_t       e;
    fr      = {stop_bit, b, 1'b0};
    t       = 0;
    aborted = 1'b0;
    if (abort_at < 0) begin
      e.is_err = ~stop_bit;
      if (stop_bit) exp_last = b;
      e.data   = exp_last;
      e.launch = cyc + 1;
      sb.push_back(e);
    end
    for (int k = 0; k < 10; k++) begin
      dur = ((k + 1) * p100 + 50) / 100 - (k * p100 + 50) / 100;
      for (int d = 0; d < dur; d++) begin
        if (t == abort_at) aborted = 1'b1;
        if (!aborted) begin
          uart_rx_i = fr[k];
          @(posedge clk_i); #1;
          t++;
        end
      end
    end
    uart_rx_i = 1'b1;
    if (aborted) begin
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      exp_last = 8'h00;
      check("rst_mid_data", {24'd0, uart_rx_data_o}, 32'h00);
      check("rst_mid_done", {31'd0, uart_rx_done_o}, 32'd0);
      check("rst_mid_ferr", {31'd0, uart_rx_ferr_o}, 32'd0);
      check("rst_mid_busy", {31'd0, uart_rx_busy_o}, 32'd0);
      rst_i = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    uart_rx_i = 1'b1;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) begin
      @(posedge clk_i); #1;
    end
    check("scoreboard_drain", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    rst_i = 1'b1;
    uart_rx_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    check("reset_data", {24'd0, uart_rx_data_o}, 32'h00);
    check("reset_done", {31'd0, uart_rx_done_o}, 32'd0);
    check("reset_ferr", {31'd0, uart_rx_ferr_o}, 32'd0);
    check("reset_busy", {31'd0, uart_rx_busy_o}, 32'd0);
    rst_i = 1'b0;
    idle(4);

    // Single frame.
    send_frame(8'hA5, 1'b1, 1600, -1);
    wait_drain();
    idle(2);
    check("busy_after_done", {31'd0, uart_rx_busy_o}, 32'd0);
    check("hold_data_a5", {24'd0, uart_rx_data_o}, 32'hA5);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, 1600, -1);
    send_frame(8'hFF, 1'b1, 1600, -1);
    send_frame(8'h55, 1'b1, 1600, -1);
    wait_drain();
    idle(10);

    // Glitch shorter than half a bit.
    uart_rx_i = 1'b0;
    repeat (5) begin @(posedge clk_i); #1; end
    check("glitch_busy_high", {31'd0, uart_rx_busy_o}, 32'd1);
    idle(7);
    check("glitch_busy_low", {31'd0, uart_rx_busy_o}, 32'd0);
    idle(20);

    // Bad stop bit, then a good frame.
    send_frame(8'h3C, 1'b0, 1600, -1);
    wait_drain();
    idle(20);
    check("ferr_keeps_data", {24'd0, uart_rx_data_o}, 32'h55);
    send_frame(8'h81, 1'b1, 1600, -1);
    wait_drain();
    idle(10);

    // Break: line held low.
    begin
      exp_t e;
      e.is_err = 1'b1;
      e.data   = exp_last;
      e.launch = cyc + 1;
      sb.push_back(e);
    end
    uart_rx_i = 1'b0;
    repeat (400) begin @(posedge clk_i); #1; end
    check("break_busy_high", {31'd0, uart_rx_busy_o}, 32'd1);
    check("break_ferr_once", sb.size(), 32'd0);
    idle(4);
    check("break_busy_low", {31'd0, uart_rx_busy_o}, 32'd0);
    idle(20);

    // Reset during bit 4 of 8'h96, then a clean frame.
    send_frame(8'h96, 1'b1, 1600, 70);
    idle(30);
    send_frame(8'h12, 1'b1, 1600, -1);
    wait_drain();
    idle(10);

    // Baud mismatch of -2% and +2%, random bytes and gaps.
    for (int k = 0; k < 100; k++) begin
      send_frame(8'($urandom_range(255)), 1'b1, (k < 50) ? 1568 : 1632, -1);
      idle($urandom_range(20));
    end
    wait_drain();
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
